// File: rtl/gshare_pht.sv
// Gshare pattern history table: 2-bit counters indexed by PC^GHR, with an in-flight index FIFO
// that resolutions drain in order. Define GSHARE_PHT_BYPASS_EN to forward same-cycle updates to predictions.
module gshare_pht #(
  parameter int HIST_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_req,
  input  logic [31:0]       pred_pc,
  input  logic [HIST_W-1:0] ghr,
  output logic              pred_ready,
  output logic              pred_valid,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic              res_taken,
  input  logic              res_mispredict,
  input  logic              flush,
  output logic              err
);

  localparam int ENTRIES = 1 << HIST_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  logic [1:0]        pht_r [ENTRIES];
  logic [HIST_W-1:0] fifo_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r, cnt_nxt_s;
  logic              ready_r, pred_valid_r, pred_taken_r, err_r;

  logic [HIST_W-1:0] idx_s, upd_idx_s;
  logic [1:0]        upd_val_s;
  logic              accept_s, pop_s, underflow_s, clear_s, push_s, taken_nxt_s;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
    end else begin
      res = (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
    end
    return res;
  endfunction

  // Request/resolution decode and next-state values
  always_comb begin
    idx_s       = pred_pc[HIST_W+1:2] ^ ghr;
    accept_s    = pred_req & ready_r;
    pop_s       = res_valid & ~flush & (count_r != {CNT_W{1'b0}});
    underflow_s = res_valid & ~flush & (count_r == {CNT_W{1'b0}});
    upd_idx_s   = fifo_r[rd_ptr_r];
    upd_val_s   = sat_update(pht_r[upd_idx_s], res_taken);
    // A mispredict squashes everything younger than the resolving branch, including a same-cycle push
    clear_s     = flush | (pop_s & res_mispredict);
    push_s      = accept_s & ~clear_s;
    if (clear_s) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      cnt_nxt_s = count_r + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};
    end
`ifdef GSHARE_PHT_BYPASS_EN
    taken_nxt_s = (pop_s && (upd_idx_s == idx_s)) ? upd_val_s[1] : pht_r[idx_s][1];
`else
    taken_nxt_s = pht_r[idx_s][1];
`endif
  end

  // Counter table: reset to weakly not-taken, updated on each popped resolution
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_r[i] <= 2'b01;
      end
    end else if (pop_s) begin
      pht_r[upd_idx_s] <= upd_val_s;
    end else begin
      pht_r[upd_idx_s] <= pht_r[upd_idx_s];
    end
  end

  // In-flight index FIFO, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_r[i] <= {HIST_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      ready_r  <= 1'b1;
    end else begin
      if (clear_s) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (push_s) begin
          fifo_r[wr_ptr_r] <= idx_s;
          wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end else begin
          rd_ptr_r <= rd_ptr_r;
        end
      end
      count_r <= cnt_nxt_s;
      ready_r <= (cnt_nxt_s < CNT_W'(DEPTH));
    end
  end

  // Registered prediction response and sticky underflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_valid_r <= 1'b0;
      pred_taken_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      pred_valid_r <= accept_s;
      pred_taken_r <= accept_s ? taken_nxt_s : 1'b0;
      err_r        <= err_r | underflow_s;
    end
  end

  assign pred_ready = ready_r;
  assign pred_valid = pred_valid_r;
  assign pred_taken = pred_taken_r;
  assign err        = err_r;

endmodule

// File: tb/tb_gshare_pht.sv
// Directed bench for gshare_pht: a reference PHT/FIFO model feeds a scoreboard of expected predictions.
module tb_gshare_pht;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic [7:0]  ghr;
  logic        pred_ready, pred_valid, pred_taken;
  logic        res_valid, res_taken, res_mispredict, flush;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [1:0] mpht [256];
  logic [7:0] mq [$];
  logic       sb [$];
  logic       merr;

  gshare_pht #(.HIST_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pred_req(pred_req), .pred_pc(pred_pc), .ghr(ghr),
    .pred_ready(pred_ready), .pred_valid(pred_valid), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .flush(flush), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mpht[i] = 2'b01;
    mq.delete();
    sb.delete();
    merr = 1'b0;
  endtask

  // One cycle: drive inputs, predict the outcome from the model, then check after the edge.
  task automatic step(input logic req, input logic [31:0] pc, input logic [7:0] g,
                      input logic rv, input logic rt, input logic rm, input logic fl);
    logic       acc, pop, exp_t;
    logic [7:0] idx, ui;
    logic [1:0] nv;
    pred_req = req; pred_pc = pc; ghr = g;
    res_valid = rv; res_taken = rt; res_mispredict = rm; flush = fl;
    chk("ready", {31'd0, pred_ready}, {31'd0, (mq.size() < 4)});
    acc = req && (mq.size() < 4);
    idx = pc[9:2] ^ g;
    pop = rv && !fl && (mq.size() > 0);
    ui  = pop ? mq[0] : 8'h00;
    nv  = mpht[ui];
    if (pop) begin
      if (rt) nv = (mpht[ui] == 2'd3) ? 2'd3 : mpht[ui] + 2'd1;
      else    nv = (mpht[ui] == 2'd0) ? 2'd0 : mpht[ui] - 2'd1;
    end
    exp_t = mpht[idx][1];
`ifdef GSHARE_PHT_BYPASS_EN
    if (pop && ui == idx) exp_t = nv[1];
`endif
    if (acc) sb.push_back(exp_t);
    if (fl) begin
      mq.delete();
    end else if (rv) begin
      if (mq.size() == 0) merr = 1'b1;
      else begin
        void'(mq.pop_front());
        mpht[ui] = nv;
        if (rm) mq.delete();
      end
    end
    if (acc && !fl && !(pop && rm)) mq.push_back(idx);
    @(posedge clk); #1;
    chk("valid", {31'd0, pred_valid}, {31'd0, acc});
    if (acc && sb.size() > 0) chk("taken", {31'd0, pred_taken}, {31'd0, sb.pop_front()});
    chk("err", {31'd0, err}, {31'd0, merr});
    pred_req = 1'b0; res_valid = 1'b0; res_taken = 1'b0; res_mispredict = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0; pred_req = 1'b0; pred_pc = 32'h0; ghr = 8'h00;
    res_valid = 1'b0; res_taken = 1'b0; res_mispredict = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, pred_valid}, 32'd0);
    chk("rst_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_err",   {31'd0, err},        32'd0);
    chk("rst_ready", {31'd0, pred_ready}, 32'd1);
    rst = 1'b1;

    // Fresh counter predicts not-taken, then train index 0 to saturation and back down
    step(1'b1, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Flush with a same-cycle push and resolution: no err, nothing left in flight
    step(1'b1, 32'h100, 8'h3c, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);

    // Fill to DEPTH, reject a fifth, then mixed push/pop while draining
    step(1'b1, 32'h10, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h24, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h38, 8'h83, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3fc, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h50, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h10, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h10, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h24, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

    // Mispredict with three in flight updates only the oldest; later resolution sets err
    step(1'b1, 32'h40, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h44, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h48, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h40, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h44, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    // Push alongside a mispredict still responds but is discarded
    step(1'b1, 32'h48, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h60, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h64, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h68, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h6c, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h70, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Same-cycle update and prediction of index 0x05
    step(1'b1, 32'h14, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h14, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h14, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mid-operation reset drops in-flight entries and restores counters
    step(1'b1, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    chk("midrst_valid", {31'd0, pred_valid}, 32'd0);
    chk("midrst_err",   {31'd0, err},        32'd0);
    chk("midrst_ready", {31'd0, pred_ready}, 32'd1);
    rst = 1'b1;
    model_reset();
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h14, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_pht.md
GSHARE_PHT -- requirements
Module: gshare_pht

Interface
REQ-001 Parameter HIST_W, default 8, global-history width and PHT index width; the PHT holds 2^HIST_W entries.
REQ-002 Parameter DEPTH, default 4, maximum in-flight predictions awaiting resolution; power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 pred_req  input  1  fetch requests a prediction this cycle.
REQ-006 pred_pc  input  32  PC of the requesting branch.
REQ-007 ghr  input  HIST_W  current global history from the history shift register.
REQ-008 pred_ready  output  1  request can be accepted this cycle.
REQ-009 pred_valid  output  1  pred_taken is valid this cycle.
REQ-010 pred_taken  output  1  predicted direction.
REQ-011 res_valid  input  1  oldest in-flight branch resolves this cycle.
REQ-012 res_taken  input  1  actual direction of the resolving branch.
REQ-013 res_mispredict  input  1  resolving branch was mispredicted; qualified by res_valid.
REQ-014 flush  input  1  discard all in-flight predictions.
REQ-015 err  output  1  sticky flag: resolution arrived while no prediction was in flight.

Function
REQ-016 Index SHALL be pred_pc[HIST_W+1:2] XOR ghr.
REQ-017 PHT entries SHALL be 2-bit saturating counters; a counter value of 2 or 3 predicts taken.
REQ-018 A request is accepted when pred_req and pred_ready are both high.
REQ-019 pred_ready SHALL be high exactly when the in-flight count is below DEPTH, computed from registered count only, with no same-cycle pop pass-through.
REQ-020 On accept, pred_valid SHALL be high on the next cycle, with pred_taken equal to the MSB of the indexed counter; otherwise pred_valid SHALL be low.
REQ-021 On accept, the index SHALL be pushed into the in-flight FIFO.
REQ-022 On res_valid with FIFO non-empty, the SHALL pop the oldest index and update its counter: increment (saturate at 3) if res_taken, else decrement (saturate at 0).
REQ-023 On res_valid with FIFO empty: no counter update; err SHALL set and stay set until reset.
REQ-024 On res_valid with res_mispredict, after the oldest is popped and updated, all younger entries SHALL be discarded; count becomes 0 next cycle.
REQ-025 A push in the same cycle as a mispredict resolution SHALL also be discarded, although its pred_valid/pred_taken are still produced.
REQ-026 flush SHALL empty the FIFO with no counter update and cancel a same-cycle push; a same-cycle res_valid SHALL be ignored, without setting err.
REQ-027 A push and a pop in the same cycle (no mispredict, no flush) SHALL leave count unchanged and keep FIFO order.
REQ-028 Without the bypass feature, a prediction reading an index updated in the same cycle SHALL use the pre-update value.

Reset
REQ-029 While rst is low: all PHT counters = 2'b01, FIFO pointers and count = 0, pred_valid = 0, pred_taken = 0, err = 0, pred_ready = 1 after release.
REQ-030 Reset asserted mid-operation SHALL drop all in-flight entries immediately, with no counter update.

Configuration
REQ-031 Macro GSHARE_PHT_BYPASS_EN: when defined, a same-cycle prediction to the index being updated SHALL use the post-update counter value; when undefined, REQ-028 applies.

Verification
REQ-032 After reset, request pc=0x0, ghr=0x00 -> next cycle pred_valid=1, pred_taken=0 (counter 01).
REQ-033 Two resolutions of index 0x00 with res_taken=1, then a request at index 0x00 -> pred_taken=1; counter value is 3 and does not exceed 3 after a further taken update.
REQ-034 Four accepted requests with no resolution -> pred_ready=0; a fifth pred_req is not accepted (no pred_valid); one res_valid -> pred_ready=1 the following cycle.
REQ-035 Three in flight, res_valid with res_mispredict=1 -> only the oldest index is updated; count=0, pred_ready=1 next cycle; a later res_valid sets err=1.
REQ-036 Same-cycle taken update of counter 01 at index 0x05 and a request to index 0x05 -> pred_taken=0 without GSHARE_PHT_BYPASS_EN, 1 with it.
